// File: rtl/osc_voice_sched_pkg.sv
// Shared types and constants for the time-multiplexed saw oscillator bank.
// Sample width comes from the `BITS macro (16 when not supplied).
`ifndef BITS
`define BITS 16
`endif

package osc_voice_sched_pkg;

  localparam int unsigned NVOICES_DEFAULT = 4;
  localparam int unsigned SAMPLE_W        = `BITS;
  localparam int unsigned PHASE_W         = `BITS + 1;

  // Full-scale phase magnitude; a phase at or above MAX-1 wraps down
  localparam logic signed [PHASE_W-1:0] PHASE_MAX = PHASE_W'(64'd1 << (SAMPLE_W - 1));

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/osc_voice_sched_if.sv
// Increment-write handshake between a controller (master) and the oscillator bank (slave).
`ifndef BITS
`define BITS 16
`endif

interface osc_voice_sched_if
  import osc_voice_sched_pkg::*;
#(
  parameter int unsigned NVOICES = NVOICES_DEFAULT
);

  localparam int unsigned VW = $clog2(NVOICES);

  logic                       cfg_valid;
  logic                       cfg_ready;
  logic [VW-1:0]              cfg_voice;
  logic signed [SAMPLE_W-1:0] cfg_inc;

  modport master (
    output cfg_valid,
    output cfg_voice,
    output cfg_inc,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_voice,
    input  cfg_inc,
    output cfg_ready
  );

endinterface

// File: rtl/osc_voice_sched_phase_step.sv
// osc_phase_step: shared combinational saw phase advance (wrap at MAX-1, else add increment).
`ifndef BITS
`define BITS 16
`endif

module osc_phase_step
  import osc_voice_sched_pkg::*;
(
  input  logic signed [PHASE_W-1:0]  phase_i,
  input  logic signed [SAMPLE_W-1:0] inc_i,
  output logic signed [PHASE_W-1:0]  phase_o
);

  localparam logic signed [PHASE_W-1:0] WRAP_AT = PHASE_MAX - PHASE_W'(1);

  always_comb begin
    if (phase_i >= WRAP_AT) begin
      phase_o = phase_i - WRAP_AT;
    end else begin
      phase_o = phase_i + PHASE_W'(inc_i);
    end
  end

endmodule

// File: rtl/osc_voice_sched.sv
// osc_voice_sched: NVOICES saw voices stepped one per cycle per tick through one phase-step unit.
// Define OSC_VOICE_SCHED_MIX_EN to add a per-frame averaged mix output (mix_valid/mix_out).
`ifndef BITS
`define BITS 16
`endif

module osc_voice_sched
  import osc_voice_sched_pkg::*;
#(
  parameter  int unsigned NVOICES = NVOICES_DEFAULT,
  localparam int unsigned VW      = $clog2(NVOICES)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       tick,
  osc_voice_sched_if.slave           cfg,
  input  logic [NVOICES-1:0]         gate,
  output logic                       busy,
  output logic                       voice_valid,
  output logic [VW-1:0]              voice_id,
  output logic signed [SAMPLE_W-1:0] voice_out,
  output logic                       frame_done,
  output logic                       overrun
`ifdef OSC_VOICE_SCHED_MIX_EN
  ,
  output logic                       mix_valid,
  output logic signed [SAMPLE_W-1:0] mix_out
`endif
);

  state_e                     state_q, state_d;
  logic [VW-1:0]              idx_q, idx_d;
  logic                       busy_q, busy_d;
  logic                       ready_q, ready_d;
  logic                       valid_q, valid_d;
  logic                       done_q, done_d;
  logic                       ovr_q, ovr_d;
  logic [VW-1:0]              id_q, id_d;
  logic signed [SAMPLE_W-1:0] out_q, out_d;

  logic signed [PHASE_W-1:0]  phase_q [NVOICES];
  logic signed [SAMPLE_W-1:0] inc_q   [NVOICES];

  logic signed [PHASE_W-1:0]  phase_cur_c;
  logic signed [PHASE_W-1:0]  step_c;
  logic signed [PHASE_W-1:0]  phase_nxt_c;
  logic                       gate_c;
  logic                       last_c;
  logic                       cfg_fire_c;

  assign phase_cur_c = phase_q[idx_q];
  assign gate_c      = gate[idx_q];
  assign last_c      = (idx_q == VW'(NVOICES - 1));
  assign phase_nxt_c = gate_c ? step_c : '0;
  // Writes only land while idle, so a frame always sees a stable increment set
  assign cfg_fire_c  = cfg.cfg_valid && ready_q;

  osc_phase_step u_step (
    .phase_i (phase_cur_c),
    .inc_i   (inc_q[idx_q]),
    .phase_o (step_c)
  );

  // Frame sequencer and registered output next-state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    ovr_d   = 1'b0;
    id_d    = id_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        valid_d = 1'b1;
        id_d    = idx_q;
        out_d   = gate_c ? SAMPLE_W'(phase_cur_c) : '0;
        ovr_d   = tick;
        idx_d   = idx_q + VW'(1);
        if (last_c) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d == ST_RUN);
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      id_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      id_q    <= id_d;
      out_q   <= out_d;
    end
  end

  // Per-voice phase and increment storage
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= '{default: '0};
      inc_q   <= '{default: '0};
    end else begin
      if (cfg_fire_c) begin
        inc_q[cfg.cfg_voice] <= cfg.cfg_inc;
      end
      if (state_q == ST_RUN) begin
        phase_q[idx_q] <= phase_nxt_c;
      end
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign busy          = busy_q;
  assign voice_valid   = valid_q;
  assign voice_id      = id_q;
  assign voice_out     = out_q;
  assign frame_done    = done_q;
  assign overrun       = ovr_q;

`ifdef OSC_VOICE_SCHED_MIX_EN
  localparam int unsigned ACC_W = SAMPLE_W + VW;

  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       mixv_q, mixv_d;
  logic signed [SAMPLE_W-1:0] mix_q, mix_d;

  // Running frame sum restarts at voice 0; average is latched the cycle after frame_done
  always_comb begin
    acc_d  = acc_q;
    mixv_d = done_q;
    mix_d  = mix_q;
    if (state_q == ST_RUN) begin
      acc_d = ((idx_q == '0) ? ACC_W'(0) : acc_q) + ACC_W'(out_d);
    end
    if (done_q) begin
      mix_d = SAMPLE_W'(acc_q >>> VW);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      mixv_q <= 1'b0;
      mix_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      mixv_q <= mixv_d;
      mix_q  <= mix_d;
    end
  end

  assign mix_valid = mixv_q;
  assign mix_out   = mix_q;
`endif

endmodule

// File: tb/tb_osc_voice_sched.sv
// Self-checking bench for osc_voice_sched: directed scenarios plus randomized traffic
// compared every cycle against a frame-timing reference model.
`ifndef BITS
`define BITS 16
`endif

module tb_osc_voice_sched;
  import osc_voice_sched_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned VW = $clog2(N);
  localparam int          BW = `BITS;
  localparam longint      MAXV = longint'(1) << (BW - 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 tick = 1'b0;
  logic [N-1:0]         gate = '1;
  logic                 busy, voice_valid, frame_done, overrun;
  logic [VW-1:0]        voice_id;
  logic signed [BW-1:0] voice_out;
`ifdef OSC_VOICE_SCHED_MIX_EN
  logic                 mix_valid;
  logic signed [BW-1:0] mix_out;
`endif

  osc_voice_sched_if #(.NVOICES(N)) cfg_if ();

  osc_voice_sched #(.NVOICES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .tick        (tick),
    .cfg         (cfg_if),
    .gate        (gate),
    .busy        (busy),
    .voice_valid (voice_valid),
    .voice_id    (voice_id),
    .voice_out   (voice_out),
    .frame_done  (frame_done),
    .overrun     (overrun)
`ifdef OSC_VOICE_SCHED_MIX_EN
    ,
    .mix_valid   (mix_valid),
    .mix_out     (mix_out)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap(input longint x, input int w);
    longint m;
    m = x & ((longint'(1) << w) - 1);
    if (m >= (longint'(1) << (w - 1))) m -= (longint'(1) << w);
    return m;
  endfunction

  // Reference model: frame started by an idle tick at cycle T owns cycles T+1..T+N,
  // slot k of that window steps voice k and its result is visible the following cycle.
  longint m_ph [N];
  longint m_inc[N];
  bit     m_active = 0;
  int     m_slot = 0;
  longint m_sum = 0, m_mixval = 0;
  bit     m_pend = 0;
  longint e_busy = 0, e_ready = 1, e_valid = 0, e_fd = 0, e_ovr = 0, e_id = 0, e_out = 0;
  longint e_mixv = 0, e_mix = 0;

  task automatic model_step();
    int k;
    if (rst) begin
      for (int i = 0; i < N; i++) begin m_ph[i] = 0; m_inc[i] = 0; end
      m_active = 0; m_pend = 0; m_sum = 0;
      e_busy = 0; e_ready = 1; e_valid = 0; e_fd = 0; e_ovr = 0; e_id = 0; e_out = 0;
      e_mixv = 0; e_mix = 0;
      return;
    end
    e_mixv = m_pend;
    if (m_pend) e_mix = m_mixval;
    m_pend = 0;
    e_valid = 0; e_fd = 0; e_ovr = 0;
    if (m_active) begin
      k = m_slot;
      e_ovr   = tick ? 1 : 0;
      e_valid = 1;
      e_id    = k;
      e_out   = gate[k] ? wrap(m_ph[k], BW) : 0;
      if (k == 0) m_sum = 0;
      m_sum += e_out;
      if (!gate[k]) m_ph[k] = 0;
      else if (m_ph[k] >= MAXV - 1) m_ph[k] = wrap(m_ph[k] - (MAXV - 1), BW + 1);
      else m_ph[k] = wrap(m_ph[k] + m_inc[k], BW + 1);
      m_slot++;
      if (m_slot == N) begin
        m_active = 0; e_fd = 1; m_pend = 1;
        m_mixval = wrap(m_sum >>> VW, BW);
      end
    end else begin
      if (cfg_if.cfg_valid) m_inc[int'(cfg_if.cfg_voice)] = longint'(cfg_if.cfg_inc);
      if (tick) begin m_active = 1; m_slot = 0; end
    end
    e_busy  = m_active ? 1 : 0;
    e_ready = m_active ? 0 : 1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  bit     mon_en = 0;
  longint seen[N];
  int     n_valid = 0;
  longint last_mix = 0;

  task automatic monitor();
    check("busy", busy, e_busy);
    check("cfg_ready", cfg_if.cfg_ready, e_ready);
    check("voice_valid", voice_valid, e_valid);
    check("frame_done", frame_done, e_fd);
    check("overrun", overrun, e_ovr);
    check("voice_id", voice_id, e_id);
    check("voice_out", voice_out, e_out);
`ifdef OSC_VOICE_SCHED_MIX_EN
    check("mix_valid", mix_valid, e_mixv);
    check("mix_out", mix_out, e_mix);
    if (mix_valid) last_mix = mix_out;
`endif
    if (voice_valid) begin
      seen[voice_id] = voice_out;
      n_valid++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en) monitor();
  end

  task automatic do_reset();
    rst = 1'b1; tick = 1'b0; cfg_if.cfg_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mon_en = 1;
    @(negedge clk);
  endtask

  task automatic write_inc(input int v, input int val, output int waited);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_voice = VW'(v);
    cfg_if.cfg_inc   = BW'(val);
    waited = 0;
    while (!cfg_if.cfg_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic tick_frame();
    int n;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("frame_timeout", (n < 20) ? 1 : 0, 1);
    @(negedge clk);
  endtask

  int w;
  int bmask, vmask, fmask, omask, rmask;
  int exp35[4] = '{0, 16384, -32768, 1};

  initial begin
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_voice = '0;
    cfg_if.cfg_inc   = '0;

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_ready", cfg_if.cfg_ready, 1);
    check("rst_valid", voice_valid, 0);
    check("rst_out", voice_out, 0);
    check("rst_id", voice_id, 0);

    // Single voice increment
    write_inc(2, 1000, w);
    tick_frame();
    check("v2_f1", seen[2], 0);
    tick_frame();
    check("v2_f2", seen[2], 1000);
    check("v0_f2", seen[0], 0);
    check("v3_f2", seen[3], 0);

    // Wrap sequence on voice 0
    do_reset();
    write_inc(0, 16384, w);
    for (int f = 0; f < 4; f++) begin
      tick_frame();
      check("wrap_seq", seen[0], exp35[f]);
    end

    // Frame timing and overrun
    do_reset();
    bmask = 0; vmask = 0; fmask = 0; omask = 0; rmask = 0;
    tick = 1'b1;
    for (int rel = 1; rel <= 8; rel++) begin
      @(negedge clk);
      if (busy)             bmask |= (1 << rel);
      if (voice_valid)      vmask |= (1 << rel);
      if (frame_done)       fmask |= (1 << rel);
      if (overrun)          omask |= (1 << rel);
      if (cfg_if.cfg_ready) rmask |= (1 << rel);
      tick = (rel == 2);
    end
    check("busy_window", bmask, 30);
    check("valid_window", vmask, 60);
    check("done_cycle", fmask, 32);
    check("overrun_cycle", omask, 8);
    check("ready_window", rmask, 480);

    // Write coincident with tick, then write held off during a frame
    do_reset();
    cfg_if.cfg_valid = 1'b1; cfg_if.cfg_voice = '0; cfg_if.cfg_inc = BW'(500);
    tick = 1'b1;
    @(negedge clk);
    cfg_if.cfg_valid = 1'b0; tick = 1'b0;
    repeat (6) @(negedge clk);
    check("same_cycle_f1", seen[0], 0);
    tick_frame();
    check("same_cycle_f2", seen[0], 500);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    check("ready_in_run", cfg_if.cfg_ready, 0);
    write_inc(1, 777, w);
    check("cfg_held", (w > 0) ? 1 : 0, 1);
    tick_frame();
    check("held_f1", seen[1], 0);
    tick_frame();
    check("held_f2", seen[1], 777);

    // Gate off/on, then reset mid-frame
    do_reset();
    gate = '1;
    write_inc(1, 1000, w);
    tick_frame();
    tick_frame();
    check("gate_pre", seen[1], 1000);
    gate[1] = 1'b0;
    tick_frame();
    check("gate_off", seen[1], 0);
    gate[1] = 1'b1;
    tick_frame();
    check("gate_restart0", seen[1], 0);
    tick_frame();
    check("gate_restart1", seen[1], 1000);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_valid = 0;
    repeat (6) @(negedge clk);
    check("valid_after_rst", n_valid, 0);

`ifdef OSC_VOICE_SCHED_MIX_EN
    // Mix average of 400/800/1200/1600
    do_reset();
    write_inc(0, 400, w);
    write_inc(1, 800, w);
    write_inc(2, 1200, w);
    write_inc(3, 1600, w);
    tick_frame();
    tick_frame();
    @(negedge clk);
    check("mix_avg", last_mix, 1000);
`endif

    // Randomized traffic checked cycle by cycle against the model
    do_reset();
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      rst  = ($urandom_range(0, 299) == 0);
      tick = ($urandom_range(0, 3) == 0);
      cfg_if.cfg_valid = ($urandom_range(0, 2) == 0);
      cfg_if.cfg_voice = VW'($urandom);
      cfg_if.cfg_inc   = BW'($urandom);
      if ($urandom_range(0, 7) == 0) gate = N'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; tick = 1'b0; cfg_if.cfg_valid = 1'b0;
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
